// File: rtl/sgd_rd_x_from_memory.sv
// sgd_rd_x_from_memory: loads the model vector x from host memory into x memory,
// fetching four 512-bit cache lines per 2048-bit entry.
module sgd_rd_x_from_memory #(
    parameter int X_ADDR_BITS = 9,
    parameter int BANK_BITS = 6,
    parameter logic [5:0] TAG_BASE = 6'b000010
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   started,
    input  logic [57:0]            addr_model,
    input  logic [31:0]            dimension,
    input  logic                   reading_x_from_host_memory_en,
    output logic                   reading_x_from_host_memory_done,
    output logic                   x_mem_wr_en,
    output logic [X_ADDR_BITS-1:0] x_mem_wr_addr,
    output logic [2047:0]          x_mem_wr_data,
    output logic [57:0]            um_tx_rd_addr,
    output logic [7:0]             um_tx_rd_tag,
    output logic                   um_tx_rd_valid,
    input  logic                   um_tx_rd_ready,
    input  logic [511:0]           um_rx_data,
    input  logic [7:0]             um_rx_rd_tag,
    input  logic                   um_rx_rd_valid,
    output logic                   um_rx_rd_ready,
    output logic [31:0]            state_counters_rd_x_from_memory
);
    typedef enum logic [2:0] {IDLE = 3'd0, POLL = 3'd1, REQ = 3'd2, WAIT = 3'd3, WRITE = 3'd4} state_t;
    localparam int EW = 33 - BANK_BITS;
    localparam logic [X_ADDR_BITS:0] MAX_ENT = {1'b1, {X_ADDR_BITS{1'b0}}};
    state_t state;
    logic en_r1, en_r2, started_r;
    logic [X_ADDR_BITS:0] entries, entry_index, idx_inc, ent_new;
    logic [EW-1:0] ent_raw;
    logic [57:0] base;
    logic [1:0] line;
    logic [3:0] mask;
    logic [3:0][511:0] slot;
    logic start, rx_acc, last;

    // entry count is the feature count rounded up to whole banks, capped at memory depth
    assign ent_raw = EW'(dimension[31:BANK_BITS]) + EW'(|dimension[BANK_BITS-1:0]);
    assign ent_new = (ent_raw > EW'(MAX_ENT)) ? MAX_ENT : ent_raw[X_ADDR_BITS:0];
    assign start = en_r1 & ~en_r2;
    assign rx_acc = um_rx_rd_valid & um_rx_rd_ready & (um_rx_rd_tag[7:2] == TAG_BASE);
    assign idx_inc = entry_index + (X_ADDR_BITS + 1)'(1);
    assign last = idx_inc == entries;
    assign state_counters_rd_x_from_memory = {17'b0, 12'(entry_index), state};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            en_r1 <= 1'b0;
            en_r2 <= 1'b0;
            started_r <= 1'b0;
            entries <= '0;
            entry_index <= '0;
            base <= '0;
            line <= '0;
            mask <= '0;
            slot <= '0;
            reading_x_from_host_memory_done <= 1'b0;
            x_mem_wr_en <= 1'b0;
            x_mem_wr_addr <= '0;
            x_mem_wr_data <= '0;
            um_tx_rd_addr <= '0;
            um_tx_rd_tag <= '0;
            um_tx_rd_valid <= 1'b0;
            um_rx_rd_ready <= 1'b0;
        end else begin
            en_r1 <= reading_x_from_host_memory_en;
            en_r2 <= en_r1;
            started_r <= started;
            reading_x_from_host_memory_done <= 1'b0;
            x_mem_wr_en <= 1'b0;
            if (rx_acc) begin
                slot[um_rx_rd_tag[1:0]] <= um_rx_data;
                mask[um_rx_rd_tag[1:0]] <= 1'b1;
            end
            case (state)
                IDLE: if (started_r) state <= POLL;
                POLL: if (start) begin
                    base <= addr_model;
                    entries <= ent_new;
                    entry_index <= '0;
                    if (ent_new == '0) reading_x_from_host_memory_done <= 1'b1;
                    else begin
                        state <= REQ;
                        um_tx_rd_valid <= 1'b1;
                        um_tx_rd_addr <= addr_model;
                        um_tx_rd_tag <= {TAG_BASE, 2'd0};
                        line <= 2'd0;
                        um_rx_rd_ready <= 1'b1;
                    end
                end
                REQ: if (um_tx_rd_ready) begin
                    if (line == 2'd3) begin
                        um_tx_rd_valid <= 1'b0;
                        state <= WAIT;
                    end else begin
                        line <= line + 2'd1;
                        um_tx_rd_addr <= um_tx_rd_addr + 58'd1;
                        um_tx_rd_tag <= {TAG_BASE, line + 2'd1};
                    end
                end
                WAIT: if (mask == 4'hf) begin
                    state <= WRITE;
                    um_rx_rd_ready <= 1'b0;
                    x_mem_wr_en <= 1'b1;
                    x_mem_wr_addr <= entry_index[X_ADDR_BITS-1:0];
                    x_mem_wr_data <= slot;
                    reading_x_from_host_memory_done <= last;
                end
                WRITE: begin
                    mask <= '0;
                    entry_index <= idx_inc;
                    if (last) state <= POLL;
                    else begin
                        state <= REQ;
                        um_tx_rd_valid <= 1'b1;
                        um_tx_rd_addr <= base + (58'(idx_inc) << 2);
                        um_tx_rd_tag <= {TAG_BASE, 2'd0};
                        line <= 2'd0;
                        um_rx_rd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sgd_rd_x_from_memory.sv
// tb_sgd_rd_x_from_memory: drives loads through a host-memory model and checks
// requests, x-memory writes and done pulses against an arithmetic reference.
module tb_sgd_rd_x_from_memory;
    localparam logic [5:0] TAG_BASE = 6'b000010;
    localparam logic [511:0] GARB = {16{32'hDEADBEEF}};

    logic clk = 0;
    logic rst_n = 0;
    logic started = 0;
    logic [57:0] addr_model = '0;
    logic [31:0] dimension = '0;
    logic en = 0;
    logic done;
    logic x_mem_wr_en;
    logic [8:0] x_mem_wr_addr;
    logic [2047:0] x_mem_wr_data;
    logic [57:0] um_tx_rd_addr;
    logic [7:0] um_tx_rd_tag;
    logic um_tx_rd_valid;
    logic um_tx_rd_ready = 0;
    logic [511:0] um_rx_data = '0;
    logic [7:0] um_rx_rd_tag = '0;
    logic um_rx_rd_valid = 0;
    logic um_rx_rd_ready;
    logic [31:0] state_cnt;

    sgd_rd_x_from_memory dut (
        .clk(clk), .rst_n(rst_n), .started(started), .addr_model(addr_model),
        .dimension(dimension), .reading_x_from_host_memory_en(en),
        .reading_x_from_host_memory_done(done), .x_mem_wr_en(x_mem_wr_en),
        .x_mem_wr_addr(x_mem_wr_addr), .x_mem_wr_data(x_mem_wr_data),
        .um_tx_rd_addr(um_tx_rd_addr), .um_tx_rd_tag(um_tx_rd_tag),
        .um_tx_rd_valid(um_tx_rd_valid), .um_tx_rd_ready(um_tx_rd_ready),
        .um_rx_data(um_rx_data), .um_rx_rd_tag(um_rx_rd_tag),
        .um_rx_rd_valid(um_rx_rd_valid), .um_rx_rd_ready(um_rx_rd_ready),
        .state_counters_rd_x_from_memory(state_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {logic [57:0] a; logic [7:0] t;} req_t;
    typedef struct {logic [8:0] a; logic [2047:0] d;} wr_t;
    typedef struct {logic [7:0] t; logic [511:0] d; int due;} rsp_t;
    req_t req_q[$];
    wr_t wr_q[$];
    rsp_t pend[$];
    int passed = 0, total = 0, fails = 0;
    int done_cnt = 0, done_wr = 0, cyc = 0, mode = 0, st = 0;
    bit stall = 0, rx_fire = 0;
    logic [57:0] s_addr;
    logic [7:0] s_tag;
    int ord[5] = '{3, 1, 4, 0, 2};

    task automatic chk(input string n, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", n, o, e);
        end
    endtask

    task automatic chk_wide(input string n, input logic [2047:0] o, input logic [2047:0] e);
        total++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s: got low64 %0h expected low64 %0h", n, o[63:0], e[63:0]);
        end
    endtask

    // host memory contents: every cache line has a distinct, address-derived pattern
    function automatic logic [511:0] mem_data(input logic [57:0] a);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = a[31:0] * 32'h9E3779B9 + 32'(i) * 32'h01234567 + 32'(a[57:32]);
        return d;
    endfunction

    function automatic void present(input logic [7:0] t, input logic [511:0] d);
        um_rx_rd_valid = 1'b1;
        um_rx_rd_tag = t;
        um_rx_data = d;
    endfunction

    // host model: accepts requests, returns responses after a delay, records writes
    always @(negedge clk) begin
        int k;
        cyc++;
        if (!rst_n) begin
            pend.delete();
            um_rx_rd_valid = 1'b0;
            um_tx_rd_ready = 1'b0;
            rx_fire = 0;
            stall = 0;
            st = 0;
        end else begin
            if (stall) begin
                chk("stall_valid", 64'(um_tx_rd_valid), 1);
                chk("stall_addr", 64'(um_tx_rd_addr), 64'(s_addr));
                chk("stall_tag", 64'(um_tx_rd_tag), 64'(s_tag));
            end
            if (x_mem_wr_en) wr_q.push_back('{x_mem_wr_addr, x_mem_wr_data});
            if (done) begin
                done_cnt++;
                if (x_mem_wr_en) done_wr++;
            end
            um_tx_rd_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (um_tx_rd_valid && um_tx_rd_ready) begin
                req_q.push_back('{um_tx_rd_addr, um_tx_rd_tag});
                pend.push_back('{um_tx_rd_tag, mem_data(um_tx_rd_addr),
                                 cyc + ((mode == 1) ? int'($urandom_range(1, 20)) : 10)});
            end
            stall = um_tx_rd_valid && !um_tx_rd_ready;
            s_addr = um_tx_rd_addr;
            s_tag = um_tx_rd_tag;
            if (rx_fire) um_rx_rd_valid = 1'b0;
            if (!um_rx_rd_valid) begin
                if (mode == 2) begin
                    if (st == 5) st = 0;
                    if (st < 5 && (st > 0 || pend.size() == 4)) begin
                        if (ord[st] == 4) present(8'h07, GARB);
                        else begin
                            k = 0;
                            for (int i = 0; i < pend.size(); i++) if (int'(pend[i].t[1:0]) == ord[st]) k = i;
                            present(pend[k].t, pend[k].d);
                            pend.delete(k);
                        end
                        st++;
                    end
                end else if (mode == 1 && pend.size() > 0 && $urandom_range(0, 7) == 0) begin
                    present({6'($urandom_range(3, 63)), 2'($urandom_range(0, 3))}, GARB);
                end else if (pend.size() > 0) begin
                    k = (mode == 1) ? int'($urandom_range(0, pend.size() - 1)) : 0;
                    if (pend[k].due <= cyc) begin
                        present(pend[k].t, pend[k].d);
                        pend.delete(k);
                    end
                end
            end
            rx_fire = um_rx_rd_valid && um_rx_rd_ready;
        end
    end

    task automatic run_load(input logic [31:0] dim, input logic [57:0] a, input int m, input bit extra);
        int e, cycles;
        logic [2047:0] ed;
        @(negedge clk);
        mode = m;
        req_q.delete();
        wr_q.delete();
        done_cnt = 0;
        done_wr = 0;
        dimension = dim;
        addr_model = a;
        en = 1;
        repeat (3) @(negedge clk);
        en = 0;
        if (extra) begin
            repeat (3) @(negedge clk);
            en = 1;
            addr_model = ~a;
            dimension = 32'd1000;
            repeat (3) @(negedge clk);
            en = 0;
        end
        cycles = 0;
        while (done_cnt == 0 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
        end
        chk("done_seen", 64'(done_cnt != 0), 1);
        repeat (30) @(negedge clk);
        e = int'((longint'(dim) + 63) / 64);
        if (e > 512) e = 512;
        chk("req_count", 64'(req_q.size()), 64'(4 * e));
        for (int i = 0; i < req_q.size() && i < 4 * e; i++) begin
            chk("req_addr", 64'(req_q[i].a), 64'(a + 58'(i)));
            chk("req_tag", 64'(req_q[i].t), 64'({TAG_BASE, 2'(i)}));
        end
        chk("wr_count", 64'(wr_q.size()), 64'(e));
        for (int j = 0; j < wr_q.size() && j < e; j++) begin
            ed = {mem_data(a + 58'(4 * j + 3)), mem_data(a + 58'(4 * j + 2)),
                  mem_data(a + 58'(4 * j + 1)), mem_data(a + 58'(4 * j))};
            chk("wr_addr", 64'(wr_q[j].a), 64'(j));
            chk_wide("wr_data", wr_q[j].d, ed);
        end
        chk("done_count", 64'(done_cnt), 1);
        chk("done_with_wr", 64'(done_wr), (e > 0) ? 64'd1 : 64'd0);
        chk("state_poll", 64'(state_cnt[2:0]), 1);
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, "_tx_valid"}, 64'(um_tx_rd_valid), 0);
        chk({n, "_tx_addr"}, 64'(um_tx_rd_addr), 0);
        chk({n, "_tx_tag"}, 64'(um_tx_rd_tag), 0);
        chk({n, "_rx_ready"}, 64'(um_rx_rd_ready), 0);
        chk({n, "_wr_en"}, 64'(x_mem_wr_en), 0);
        chk({n, "_wr_addr"}, 64'(x_mem_wr_addr), 0);
        chk_wide({n, "_wr_data"}, x_mem_wr_data, '0);
        chk({n, "_done"}, 64'(done), 0);
        chk({n, "_state_cnt"}, 64'(state_cnt), 0);
    endtask

    initial begin
        int cycles;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("idle_until_started", 64'(state_cnt[2:0]), 0);
        started = 1;
        repeat (3) @(negedge clk);
        chk("poll_after_started", 64'(state_cnt[2:0]), 1);

        run_load(32'd128, 58'h1000, 0, 0);
        run_load(32'd65, 58'({$urandom, $urandom}), 1, 0);
        run_load(32'd64, 58'({$urandom, $urandom}), 1, 0);
        run_load(32'd0, 58'({$urandom, $urandom}), 0, 0);
        run_load(32'd64, 58'({$urandom, $urandom}), 2, 0);
        run_load(32'd200, 58'({$urandom, $urandom}), 1, 1);
        run_load(32'd128, 58'({$urandom, $urandom}), 1, 0);

        @(negedge clk);
        mode = 0;
        req_q.delete();
        dimension = 32'd128;
        addr_model = 58'h2000;
        en = 1;
        repeat (3) @(negedge clk);
        en = 0;
        cycles = 0;
        while (req_q.size() < 2 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        chk("pre_reset_reqs", 64'(req_q.size() >= 2), 1);
        @(posedge clk);
        #2 rst_n = 0;
        #1 chk_all_zero("async_reset");
        repeat (3) @(negedge clk);
        chk("reset_rx_ready", 64'(um_rx_rd_ready), 0);
        rst_n = 1;
        repeat (5) @(negedge clk);
        chk("poll_after_reset", 64'(state_cnt[2:0]), 1);
        run_load(32'd128, 58'({$urandom, $urandom}), 0, 0);
        run_load(32'hFFFF_FFFF, 58'({$urandom, $urandom}), 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sgd_rd_x_from_memory.md
Name: sgd_rd_x_from_memory

Overview:
- Loads the model vector x from host memory into the on-chip x memory before training starts (the initial or warm-start model).
- It is the read counterpart of the path that writes x back to host memory.
- Per x-memory entry, it issues 4 host cache-line reads of 512 bits each, reassembles them into one 2048-bit entry, and writes the entry to x memory.
- It sits between the root control module, the host memory read channel (um_tx_rd / um_rx_rd), and the write port of the x memory.

Parameters:
X_ADDR_BITS, 9, width of x_mem_wr_addr; the x memory holds up to 2^X_ADDR_BITS entries.
BANK_BITS, 6, log2 of features per x entry (64 features x 32 bits = 2048 bits).
TAG_BASE, 6'b000010, upper 6 bits of um_tx_rd_tag used by this block.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
started  in  1  level; parameters valid once high
addr_model  in  58  cache-line address of x in host memory
dimension  in  32  number of features
reading_x_from_host_memory_en  in  1  level; each rising edge starts one load
reading_x_from_host_memory_done  out  1  one-cycle pulse at load completion
x_mem_wr_en  out  1  x memory write strobe
x_mem_wr_addr  out  X_ADDR_BITS  x memory entry address
x_mem_wr_data  out  2048  assembled entry
um_tx_rd_addr  out  58  read request cache-line address
um_tx_rd_tag  out  8  {TAG_BASE, line[1:0]}
um_tx_rd_valid  out  1  read request valid
um_tx_rd_ready  in  1  request accepted when valid & ready
um_rx_data  in  512  read response data
um_rx_rd_tag  in  8  response tag
um_rx_rd_valid  in  1  response valid
um_rx_rd_ready  out  1  response accepted when valid & ready
state_counters_rd_x_from_memory  out  32  debug: {17'b0, entry_index[11:0], state[2:0]}

Behaviour:
- Clock and reset: one clock; the reset is asynchronous and active-low. Reset clears every output to 0, the FSM to IDLE, and all counters and the line mask to 0.
- All outputs are registered.
- Entry count: entries = dimension[31:BANK_BITS] + (dimension[BANK_BITS-1:0] != 0), saturated at 2^X_ADDR_BITS.
  - Latched together with addr_model on the start edge.
  - Later changes to either input during a load have no effect.
- Addressing: line address = addr_model + entry_index*4 + line. Index 0 is bits [511:0] of the entry; line 3 is bits [2047:1536].
- Edge detection: reading_x_from_host_memory_en is registered twice. Start = r1 & ~r2.
- FSM encoding: IDLE=0, POLL=1, REQ=2, WAIT=3, WRITE=4.
- IDLE: go to POLL when started is high (registered once).
- POLL:
  - On start: latch the parameters and set entry_index=0.
  - If entries==0: pulse done the next cycle and stay in POLL.
  - Otherwise go to REQ.
  - Starts seen in any other state are ignored.
- REQ:
  - Drive um_tx_rd_valid=1 with line index 0..3, advancing on each valid&ready.
  - Valid, addr and tag stay stable while ready is low.
  - After line 3 is accepted, drop valid and go to WAIT.
  - Responses are also accepted while in REQ.
- Response collection:
  - um_rx_rd_ready=1 in REQ and WAIT, 0 otherwise.
  - On valid&ready with tag[7:2]==TAG_BASE: store um_rx_data into the slot given by tag[1:0] and set mask[tag[1:0]].
  - Responses may arrive in any order.
  - A duplicate tag overwrites its slot; the mask is unchanged.
  - A response with foreign upper tag bits is consumed and dropped.
- WAIT: when the mask equals 4'b1111, go to WRITE.
- WRITE:
  - For exactly one cycle, x_mem_wr_en=1, x_mem_wr_addr=entry_index, x_mem_wr_data=assembled entry.
  - Clear the mask and increment entry_index.
  - If this was the last entry, pulse done in the same cycle and go to POLL; otherwise go to REQ.
- Outstanding reads: at most 4 per entry (one entry in flight).
- Best-case throughput: 4 request cycles + response latency + 1 write cycle per entry.
- Enable deasserted mid-load: ignored; the load runs to completion.
- Reset mid-load: immediate abort and return to IDLE. Responses that arrive later are not accepted, because ready=0.

Test Plan:
- dimension=128, addr_model=0x1000, ready tied high, in-order responses after 10 cycles:
  - requested addresses are 0x1000..0x1007 with tags 0x08..0x0B twice;
  - two writes occur, to addr 0 and addr 1, with correctly placed data;
  - done pulses once, together with the second x_mem_wr_en.
- dimension=65 -> 2 entries (ceiling); dimension=64 -> 1 entry; dimension=0 -> no requests and a single done pulse.
- Responses for tags 0x0B, 0x09, 0x08, 0x0A (out of order), plus a foreign tag 0x07 in the middle:
  - the entry equals {d3,d2,d1,d0};
  - the 0x07 data never appears.
- um_tx_rd_ready toggled randomly -> addr/tag stay stable during stalls; no request is lost or duplicated.
- Second rising edge of en during a busy load -> ignored. A rising edge after done -> a new load with freshly latched addr_model.
- rst_n asserted between lines 1 and 2 -> all outputs read 0 asynchronously, state=IDLE; a subsequent start completes normally.
